// File: rtl/bf16_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined BF16 multiplier.
// master drives operands and consumes results; slave is the multiplier.
interface bf16_mul_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/bf16_mul_pipe.sv
// Three-stage BF16 multiplier: unpack/classify, 8x8 significand product,
// normalize/round-to-nearest-even/pack. Whole pipe stalls on backpressure.
module bf16_mul_pipe #(
   parameter int FLUSH_SUBNORM = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   bf16_mul_pipe_if.slave  bus
);
   localparam int STAGES = 3;

   typedef struct packed {
      logic              sign;
      logic              nan_inv;
      logic              inf;
      logic              zero;
      logic [7:0]        sa;
      logic [7:0]        sb;
      logic signed [9:0] esum;
   } s1_t;

   typedef struct packed {
      logic              sign;
      logic              nan_inv;
      logic              inf;
      logic              zero;
      logic [15:0]       p;
      logic signed [9:0] esum;
   } s2_t;

   logic [STAGES:1] vld_pipe;
   logic            adv;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;
   logic [15:0]     res_d, res_q;
   logic [3:0]      flg_d, flg_q;

   logic [7:0] ea, eb;
   logic [6:0] ma, mb;
   logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign adv           = !vld_pipe[STAGES] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_pipe[STAGES];
   assign bus.result    = res_q;
   assign bus.flags     = flg_q;

   // Stage 1: classify; exp==0 is treated as zero (subnormals flushed)
   always_comb begin
      ea     = bus.a[14:7];
      eb     = bus.b[14:7];
      ma     = bus.a[6:0];
      mb     = bus.b[6:0];
      a_zero = (ea == 8'd0) && ((FLUSH_SUBNORM != 0) || (ma == 7'd0));
      b_zero = (eb == 8'd0) && ((FLUSH_SUBNORM != 0) || (mb == 7'd0));
      a_inf  = (ea == 8'hFF) && (ma == 7'd0);
      b_inf  = (eb == 8'hFF) && (mb == 7'd0);
      a_nan  = (ea == 8'hFF) && (ma != 7'd0);
      b_nan  = (eb == 8'hFF) && (mb != 7'd0);

      s1_d         = '0;
      s1_d.sign    = bus.a[15] ^ bus.b[15];
      s1_d.nan_inv = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      s1_d.inf     = a_inf || b_inf;
      s1_d.zero    = a_zero || b_zero;
      s1_d.sa      = {1'b1, ma};
      s1_d.sb      = {1'b1, mb};
      s1_d.esum    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
   end

   // Stage 2: significand product
   always_comb begin
      s2_d         = '0;
      s2_d.sign    = s1_q.sign;
      s2_d.nan_inv = s1_q.nan_inv;
      s2_d.inf     = s1_q.inf;
      s2_d.zero    = s1_q.zero;
      s2_d.p       = 16'(s1_q.sa) * 16'(s1_q.sb);
      s2_d.esum    = s1_q.esum;
   end

   // Stage 3: normalize, round, then apply special cases in priority order
   logic              hi, guard, sticky, rnd;
   logic [7:0]        sig8;
   logic [8:0]        sig9;
   logic [6:0]        mant;
   logic signed [9:0] e1, e2;

   always_comb begin
      hi     = s2_q.p[15];
      sig8   = hi ? s2_q.p[15:8] : s2_q.p[14:7];
      guard  = hi ? s2_q.p[7]    : s2_q.p[6];
      sticky = hi ? |s2_q.p[6:0] : |s2_q.p[5:0];
      e1     = s2_q.esum + 10'(hi);
      rnd    = guard && (sticky || sig8[0]);
      sig9   = {1'b0, sig8} + 9'(rnd);
      // carry out of the significand leaves 0x80, i.e. stored mantissa 0
      mant   = sig9[8] ? 7'd0 : sig9[6:0];
      e2     = sig9[8] ? e1 + 10'sd1 : e1;

      res_d = {s2_q.sign, e2[7:0], mant};
      flg_d = {3'b000, guard || sticky};
      if (s2_q.nan_inv) begin
         res_d = 16'h7FC0;
         flg_d = 4'b1000;
      end else if (s2_q.inf) begin
         res_d = {s2_q.sign, 8'hFF, 7'h00};
         flg_d = 4'b0000;
      end else if (s2_q.zero) begin
         res_d = {s2_q.sign, 15'h0000};
         flg_d = 4'b0000;
      end else if (e2 >= 10'sd255) begin
         res_d = {s2_q.sign, 8'hFF, 7'h00};
         flg_d = 4'b0101;
      end else if (e2 <= 10'sd0) begin
         res_d = {s2_q.sign, 15'h0000};
         flg_d = 4'b0011;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         res_q    <= '0;
         flg_q    <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         res_q    <= res_d;
         flg_q    <= flg_d;
      end
   end
endmodule

// File: doc/bf16_mul_pipe.md
Name: bf16_mul_pipe

Overview:
- Pipelined BFloat16 multiplier; the inverse-operation companion to the combinational BF16 divider in the FPU datapath.
- Accepts one operand pair per cycle on a valid/ready interface and returns the product 3 cycles later.
- Downstream backpressure stalls the whole pipeline.
- Used where the divider's results are rescaled or checked by multiply-back (q*b ≈ a).

Parameters:
- FLUSH_SUBNORM, 1, when 1 subnormal inputs and results are flushed to signed zero (only supported value; 0 is reserved).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair a/b valid
- in_ready  out  1  block can accept a/b this cycle
- a  in  16  BF16 multiplicand {sign, exp[7:0], mant[6:0]}
- b  in  16  BF16 multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  16  BF16 product a*b
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0; result=16'h0000; flags=4'h0. in_ready=1 once reset is released.
- Pipeline advance: adv = !out_valid || out_ready. All three stages shift together when adv=1 and hold when adv=0. in_ready = adv, combinational.
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Latency: exactly 3 cycles from input acceptance to out_valid when no stall. Throughput: 1 result per cycle.
- result and flags hold stable while out_valid=1 && out_ready=0.
- Stage 1 (unpack/classify):
  - sign = a[15]^b[15].
  - Classify each operand: zero (exp=0, any mantissa, flushed), inf (exp=255, mant=0), NaN (exp=255, mant≠0), normal.
  - Form 8-bit significands {1,mant}.
  - exp_sum = a.exp + b.exp − 127, computed signed in 10 bits.
- Stage 2: 16-bit product P = sigA*sigB, registered.
- Stage 3 (normalize/round/pack):
  - If P[15]=1: keep P[15:8], guard=P[7], sticky=|P[6:0], exp_sum+1.
  - Else: keep P[14:7], guard=P[6], sticky=|P[5:0].
  - Round to nearest even: increment when guard && (sticky || lsb).
  - If the increment carries out of the 8-bit significand, significand becomes 0x80 and exp+1.
  - inexact = guard || sticky.
- Special-case priority, highest first:
  - Any NaN, or inf×zero: result=16'h7FC0 (sign 0), invalid=1, other flags 0.
  - Inf operand: result = {sign, 8'hFF, 7'h0}.
  - Zero operand: result = {sign, 15'h0}.
  - Final exp ≥ 255: result = {sign, 8'hFF, 7'h0}, overflow=1, inexact=1.
  - Final exp ≤ 0: result = {sign, 15'h0}, underflow=1, inexact=1.
  - Otherwise: {sign, exp[7:0], mant[6:0]} with inexact per rounding.
- Stall boundary: with out_valid=1 && out_ready=0, up to 3 results are held (stages 1-3). No input is accepted and none is dropped or duplicated.
- Simultaneous input accept and output consume in the same cycle is legal and is the normal streaming case.
- Bubbles: in_valid=0 while adv=1 inserts an invalid slot; bubbles compress only when the final stage is empty.
- rst_n asserted mid-operation discards all in-flight data immediately; out_valid drops asynchronously.

Test Plan:
- 0x4000 × 0x4040 (2.0×3.0), out_ready=1 -> result 0x40C0 exactly 3 cycles after accept, flags 0000.
- 0x3FC0×0x3F81 (1.5×1.0078125, tie, odd lsb) -> 0x3FC2, inexact=1. Then 0x3FC0×0x3F83 (tie, even lsb) -> 0x3FC4, inexact=1.
- 0x3F81×0x40FF (normalizing shift, P=0x807F) -> 0x4100, inexact=1. Also 0x7F80×0x0000 -> 0x7FC0, invalid=1. Also 0x7F00×0x7F00 -> 0x7F80, overflow=1.
- Underflow 0x0080×0x0080 -> 0x0000, underflow=1. Sign check 0xC000×0x4000 -> 0xC080.
- Backpressure: stream 5 pairs back-to-back, hold out_ready=0 after the first result appears -> in_ready=0 while stalled, result stable. Release out_ready -> all 5 products emerge in order, no loss or duplication.
- Assert rst_n=0 with 3 ops in flight -> out_valid=0, result=0x0000 immediately. After release, the first new op returns in 3 cycles with no stale data.
